// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage indices, stage count and the packed
// RV32I control word carried by the control-path register chain.
package pipe_pkg;

    localparam int STG_IF_ID  = 0;
    localparam int STG_ID_EX  = 1;
    localparam int STG_EX_MEM = 2;
    localparam int STG_MEM_WB = 3;

    localparam int NUM_STAGES = 4;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] imm_sel;
        logic       alu_src_imm;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       jump;
        wb_sel_e    wb_sel;
    } rv32i_control_word;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline buffer: payload + valid with flush > hold > bubble > advance
// priority and asynchronous active-low reset.
module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             hold,
    input  logic             bubble,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             prev_valid,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush) begin
            data_d  = RESET_VAL;
            valid_d = 1'b0;
        end else if (hold) begin
            data_d  = data_q;
            valid_d = valid_q;
        end else if (bubble) begin
            data_d  = RESET_VAL;
            valid_d = 1'b0;
        end else begin
            data_d  = prev_data;
            valid_d = prev_valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// STAGES-deep pipeline register chain with per-stage stall/flush.
// Optional PIPE_REG_CHAIN_STATS_EN adds saturating stall/bubble counters.
//
// Handshake: in is consumed at an edge exactly when in_ready=1; in_ready
// is ~hold[0], so the producer must keep in stable while in_ready=0.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               STAGES    = NUM_STAGES,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    output logic [STAGES*WIDTH-1:0] data_out,
    output logic [STAGES-1:0]       valid_out
`ifdef PIPE_REG_CHAIN_STATS_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             bubble_count
`endif
);

    logic [STAGES-1:0] hold;
    logic [WIDTH-1:0]  stage_data [STAGES];

    // A stall freezes its own stage and everything upstream of it.
    always_comb begin
        hold = '0;
        hold[STAGES-1] = stall[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            hold[i] = stall[i] | hold[i+1];
        end
    end

    assign in_ready = ~hold[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_first
            pipe_stage_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .flush     (flush[0]),
                .hold      (hold[0]),
                .bubble    (1'b0),
                .prev_data (in),
                .prev_valid(in_valid),
                .data      (stage_data[0]),
                .valid     (valid_out[0])
            );
        end else begin : g_rest
            pipe_stage_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .flush     (flush[i]),
                .hold      (hold[i]),
                .bubble    (hold[i-1] & ~hold[i]),
                .prev_data (stage_data[i-1]),
                .prev_valid(valid_out[i-1]),
                .data      (stage_data[i]),
                .valid     (valid_out[i])
            );
        end
        assign data_out[i*WIDTH +: WIDTH] = stage_data[i];
    end

`ifdef PIPE_REG_CHAIN_STATS_EN
    logic        any_bubble;
    logic [31:0] stall_cycles_d, stall_cycles_q;
    logic [31:0] bubble_count_d, bubble_count_q;

    // A flushed stage is cleared, not bubbled, so it does not count.
    always_comb begin
        any_bubble = 1'b0;
        for (int i = 1; i < STAGES; i++) begin
            if (hold[i-1] && !hold[i] && !flush[i]) begin
                any_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        bubble_count_d = bubble_count_q;
        if (hold[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (any_bubble && (bubble_count_q != 32'hFFFF_FFFF)) begin
            bubble_count_d = bubble_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            bubble_count_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
Parametrised pipeline-register chain carrying one payload word (PC, IR or packed control word) through STAGES pipeline buffers (IF_ID, ID_EX, EX_MEM, MEM_WB for STAGES=4).
Each stage has a valid bit, per-stage stall and per-stage flush:
- a stall freezes its stage and everything upstream, and inserts bubbles downstream;
- a flush kills the stage's contents.
One instance per payload type sits beside the datapath and is driven by the hazard/forwarding control unit.

Parameters:
WIDTH, 32, payload bits per stage (>=1)
STAGES, 4, number of pipeline buffers (>=2)
RESET_VAL, 0, payload value loaded on reset, flush or bubble (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset, asynchronous, active-low; clears all stages
in  input  WIDTH  payload entering stage 0
in_valid  input  1  payload on in is a real instruction
in_ready  output  1  stage 0 will capture in this cycle (= ~hold[0])
stall  input  STAGES  stall[i] freezes stage i this cycle
flush  input  STAGES  flush[i] invalidates stage i at this edge
data_out  output  STAGES*WIDTH  stage i payload at bits [i*WIDTH +: WIDTH]
valid_out  output  STAGES  stage i valid bit

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, asynchronous, any time including mid-stall): every payload = RESET_VAL, every valid = 0. Outputs are registered and visible with no clock edge.
- hold[i] = OR of stall[j] for j >= i. This is combinational; a stall propagates upstream in the same cycle.
- in_ready = ~hold[0]. This is purely combinational from stall.
- Per stage i at a rising edge, with priority flush > hold > bubble > advance:
  - flush[i]=1: payload <= RESET_VAL, valid <= 0. Applies even if hold[i]=1.
  - hold[i]=1: payload and valid retained.
  - i>0, hold[i]=0 and hold[i-1]=1: bubble. Payload <= RESET_VAL, valid <= 0.
  - otherwise advance:
    - stage 0 loads in / in_valid;
    - stage i>0 loads stage i-1 payload/valid.
- A flush of stage i does not stop upstream stages advancing. Stage i+1 takes stage i's pre-flush contents at the same edge, unless flush[i+1] is also set.
- Latency: an accepted word appears at stage k exactly k+1 edges after acceptance, plus one extra edge per cycle that stage was held.
- An invalid entry (in_valid=0) advances like any payload. The payload is still captured, and only valid marks it.
- All stages held (stall[STAGES-1]=1): chain fully frozen, in_ready=0, no loss.
- stall and flush asserted on the same stage: flush wins. Upstream stages stay held because of that stall.
- No wrap-around. The last stage's contents are discarded when it advances.

Optional Feature:
Macro PIPE_REG_CHAIN_STATS_EN.
- Defined:
  - extra outputs stall_cycles[31:0] and bubble_count[31:0];
  - stall_cycles increments on each edge with hold[0]=1;
  - bubble_count increments on each edge where any stage takes a bubble (one per edge, not per stage);
  - both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared package pipe_pkg holds:
  - stage index constants STG_IF_ID=0, STG_ID_EX=1, STG_EX_MEM=2, STG_MEM_WB=3;
  - localparam NUM_STAGES=4;
  - the rv32i_control_word typedef, so WIDTH=$bits(rv32i_control_word) can be used.
- Sub-module pipe_stage_reg: a single stage with the flush/hold/bubble/advance priority and async active-low reset, instantiated STAGES times by a generate loop. The top computes hold[] and the counters.

Test Plan:
- Reset mid-run: load 32'hA, 32'hB; drop reset between edges → all data_out=0, valid_out=4'b0000 immediately, before the next edge.
- Free flow: WIDTH=32, STAGES=4, in=1,2,3,4,5 with valid, no stall → after edge 4 data_out stages 0..3 = 4,3,2,1 and valid_out=4'b1111.
- Load-use stall: chain holds 4,3,2,1; stall=4'b0010 for one cycle with in=5 → in_ready=0; after the edge stages = 4,3,bubble(0,valid 0),2.
- Branch flush: chain 4,3,2,1; flush=4'b0011, in=9 → after the edge stage0=0/v0, stage1=0/v0, stage2=3, stage3=2.
- Flush and stall on the same stage: stall=4'b0100, flush=4'b0100 → stage2 cleared, stages 0–1 retained, stage3 bubble, in_ready=0.
- Stats (macro on): stall=4'b0001 held 3 cycles then 0 → stall_cycles=3, bubble_count=3; the counters are forced to 32'hFFFF_FFFF and stay saturated.
